half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the carry-event counter (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all sequential logic rising-edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: A  input  1  addend bit A.
REQ-005 Port: B  input  1  addend bit B.
REQ-006 Port: en  input  1  capture enable for registered outputs and counter.
REQ-007 Port: clr  input  1  synchronous clear of counter and saturation flag.
REQ-008 Port: Sum  output  1  combinational sum, A XOR B.
REQ-009 Port: Cout  output  1  combinational carry, A AND B.
REQ-010 Port: Sum_q  output  1  registered Sum.
REQ-011 Port: Cout_q  output  1  registered Cout.
REQ-012 Port: carry_cnt  output  CNT_W  count of enabled cycles with Cout=1.
REQ-013 Port: cnt_sat  output  1  sticky flag, counter has reached all-ones.

Function
REQ-014 Sum SHALL equal A XOR B and Cout SHALL equal A AND B, purely combinationally, with zero-cycle latency.
REQ-015 Sum and Cout SHALL NOT depend on clk, rst, en or clr, and SHALL be correct even when those inputs are undriven.
REQ-016 Truth table: 00->Sum0 Cout0; 01->1,0; 10->1,0; 11->0,1.
REQ-017 On a rising clk edge with en=1, Sum_q/Cout_q SHALL load the current Sum/Cout (1-cycle latency); with en=0 they SHALL hold.
REQ-018 On a rising edge with en=1, Cout=1, clr=0 and carry_cnt below all-ones, carry_cnt SHALL increment by 1.
REQ-019 carry_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 cnt_sat SHALL be set in the same edge that carry_cnt becomes all-ones, and SHALL stay set until clr or rst.
REQ-021 clr=1 at an edge SHALL zero carry_cnt and cnt_sat regardless of en/Cout; clr has priority over increment.
REQ-022 clr SHALL NOT affect Sum_q/Cout_q.
REQ-023 Arithmetic SHALL be unsigned; the counter increments by exactly one per qualifying cycle.

Reset
REQ-024 rst=1 SHALL immediately, without a clock, force Sum_q=0, Cout_q=0, carry_cnt=0 and cnt_sat=0.
REQ-025 While rst=1, registers SHALL hold the reset values; Sum/Cout SHALL continue to track A and B.
REQ-026 On rst deassertion, normal operation SHALL resume at the first subsequent rising clk edge.
REQ-027 Reset asserted mid-count SHALL discard the count; no partial state survives.

Structure
REQ-028 Package half_adder_pkg SHALL hold the CNT_W default constant and a saturating-max helper constant/function.
REQ-029 The saturating counter SHALL be a sub-module, half_adder_sat_counter (inc, clr, value, sat), instantiated once.
REQ-030 The combinational sum/carry logic SHALL be continuous assignments in the top module.

Verification
REQ-031 Drive A,B = 00, 01, 10, 11 with 10 ns spacing and clk/rst undriven -> Sum/Cout = 0/0, 1/0, 1/0, 0/1.
REQ-032 rst=1 then release; en=1, A=B=1 for 3 cycles -> Cout_q=1 after the 1st edge, carry_cnt=3.
REQ-033 CNT_W=2, en=1, A=B=1 for 5 cycles -> carry_cnt stops at 3, cnt_sat=1 from the 3rd edge.
REQ-034 Same edge clr=1, en=1, Cout=1 -> carry_cnt=0, cnt_sat=0.
REQ-035 Assert rst asynchronously mid-cycle with carry_cnt=2 -> carry_cnt, Sum_q, Cout_q go to 0 before the next edge.
REQ-036 en=0, toggle A/B for 4 cycles -> Sum_q/Cout_q/carry_cnt hold while Sum/Cout follow the inputs.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half adder with its carry-event counter.
package half_adder_pkg;

  localparam int CNT_W_DEF = 8;

  // All-ones value for a counter of width w (1..32), used as the saturation ceiling.
  function automatic logic [31:0] sat_max(input int w);
    logic [31:0] r;
    if (w >= 32) r = 32'hFFFF_FFFF;
    else         r = (32'd1 << w) - 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_sat_counter.sv
// Saturating up-counter with sticky saturation flag; clr has priority over inc.
module half_adder_sat_counter
  import half_adder_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         sat
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [W-1:0] value_d, value_q;
  logic         sat_d, sat_q;

  always_comb begin
    value_d = value_q;
    sat_d   = sat_q;
    if (clr) begin
      value_d = '0;
      sat_d   = 1'b0;
    end else if (inc && (value_q != MAX)) begin
      value_d = value_q + W'(1);
      // Flag rises on the same edge the count reaches all-ones.
      if (value_q == MAX - W'(1)) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      sat_q   <= sat_d;
    end
  end

  assign value = value_q;
  assign sat   = sat_q;

endmodule

// File: rtl/half_adder.sv
// Half adder with combinational and registered outputs plus a saturating carry-event counter.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             en,
  input  logic             clr,
  output logic             Sum,
  output logic             Cout,
  output logic             Sum_q,
  output logic             Cout_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_sat
);

  // Pure gates: independent of clk/rst/en/clr.
  assign Sum  = A ^ B;
  assign Cout = A & B;

  logic sum_d, sum_q;
  logic cout_d, cout_q;

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    if (en) begin
      sum_d  = Sum;
      cout_d = Cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum_q  = sum_q;
  assign Cout_q = cout_q;

  half_adder_sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (en & Cout),
    .clr   (clr),
    .value (carry_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: truth table, registered outputs, saturation, clear and async reset.
module tb_half_adder;

  logic       clk;
  logic       rst;
  logic       A, B, en, clr;
  logic       clk_on;

  logic       sum8, cout8, sumq8, coutq8, sat8;
  logic [7:0] cnt8;
  logic       sum2, cout2, sumq2, coutq2, sat2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_errors = 0;

  half_adder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .en(en), .clr(clr),
    .Sum(sum8), .Cout(cout8), .Sum_q(sumq8), .Cout_q(coutq8),
    .carry_cnt(cnt8), .cnt_sat(sat8)
  );

  half_adder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .en(en), .clr(clr),
    .Sum(sum2), .Cout(cout2), .Sum_q(sumq2), .Cout_q(coutq2),
    .carry_cnt(cnt2), .cnt_sat(sat2)
  );

  // Clock/reset block: clk stays undriven until the clocked phase begins.
  initial begin
    clk_on = 1'b0;
    wait (clk_on);
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_regs(input string tag, input logic sq, input logic cq,
                          input int c8, input logic s8, input int c2, input logic s2);
    chk({tag, ".Sum_q"},   32'(sumq8),  32'(sq));
    chk({tag, ".Cout_q"},  32'(coutq8), 32'(cq));
    chk({tag, ".cnt8"},    32'(cnt8),   32'(c8));
    chk({tag, ".sat8"},    32'(sat8),   32'(s8));
    chk({tag, ".cnt2"},    32'(cnt2),   32'(c2));
    chk({tag, ".sat2"},    32'(sat2),   32'(s2));
  endtask

  typedef struct {
    logic a;
    logic b;
    logic sum;
    logic cout;
  } vec_t;

  vec_t tt[4];

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    en  = 1'b0;
    clr = 1'b0;

    // Combinational truth table with clk/rst left undriven.
    for (int i = 0; i < 4; i++) begin
      A = tt[i].a;
      B = tt[i].b;
      #5;
      chk($sformatf("tt%0d.Sum", i),   32'(sum8),  32'(tt[i].sum));
      chk($sformatf("tt%0d.Cout", i),  32'(cout8), 32'(tt[i].cout));
      chk($sformatf("tt%0d.Sum2", i),  32'(sum2),  32'(tt[i].sum));
      #5;
    end

    // Reset phase.
    clk_on = 1'b1;
    rst = 1'b1;
    #12;
    chk_regs("reset", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Three carry cycles, then two more to push the 2-bit counter into saturation.
    en = 1'b1; A = 1'b1; B = 1'b1;
    tick(); chk_regs("c1", 1'b0, 1'b1, 1, 1'b0, 1, 1'b0);
    tick(); chk_regs("c2", 1'b0, 1'b1, 2, 1'b0, 2, 1'b0);
    tick(); chk_regs("c3", 1'b0, 1'b1, 3, 1'b0, 3, 1'b1);
    tick(); chk_regs("c4", 1'b0, 1'b1, 4, 1'b0, 3, 1'b1);
    tick(); chk_regs("c5", 1'b0, 1'b1, 5, 1'b0, 3, 1'b1);

    // Clear wins over a qualifying increment and leaves Sum_q/Cout_q alone.
    clr = 1'b1;
    tick(); chk_regs("clr", 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    clr = 1'b0;
    tick(); tick(); chk_regs("post_clr", 1'b0, 1'b1, 2, 1'b0, 2, 1'b0);

    // en=0: registers hold while combinational outputs follow the inputs.
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = tt[i].a;
      B = tt[i].b;
      tick();
      chk($sformatf("hold%0d.Sum", i),  32'(sum8),  32'(tt[i].sum));
      chk($sformatf("hold%0d.Cout", i), 32'(cout8), 32'(tt[i].cout));
      chk_regs($sformatf("hold%0d", i), 1'b0, 1'b1, 2, 1'b0, 2, 1'b0);
    end

    // Asynchronous reset mid-cycle with count=2: must clear before the next edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    A = 1'b1; B = 1'b0;
    #1;
    chk_regs("async_rst", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("rst.Sum",  32'(sum8),  32'd1);
    chk("rst.Cout", 32'(cout8), 32'd0);
    en = 1'b1;
    tick();
    chk_regs("rst_hold", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

    // Resume at the first edge after release.
    @(negedge clk);
    rst = 1'b0;
    tick(); chk_regs("resume", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    A = 1'b1; B = 1'b1;
    tick(); chk_regs("resume2", 1'b0, 1'b1, 1, 1'b0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
